// File: rtl/dot_product_pe.sv
// Serial dot-product processing element: latches one row/column pair,
// accumulates one product per cycle, then pushes the sum downstream.
module dot_product_pe #(
  parameter int DATA_W = 8,
  parameter int K      = 4,
  parameter int ACC_W  = 2*DATA_W + $clog2(K)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_PE,
  input  logic [K*DATA_W-1:0]       a_row,
  input  logic [K*DATA_W-1:0]       b_col,
  input  logic                      fifo_full,
  output logic                      PE_ready,
  output logic                      busy,
  output logic                      fifo_push,
  output logic signed [ACC_W-1:0]   fifo_wdata
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K-1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [K*DATA_W-1:0]       a_q, a_d;
  logic [K*DATA_W-1:0]       b_q, b_d;

  logic signed [DATA_W-1:0]   a_el, b_el;
  logic signed [2*DATA_W-1:0] prod;

  assign a_el = a_q[32'(idx_q)*DATA_W +: DATA_W];
  assign b_el = b_q[32'(idx_q)*DATA_W +: DATA_W];
  assign prod = a_el * b_el;

  assign PE_ready   = (state_q == IDLE);
  assign busy       = !PE_ready;
  assign fifo_push  = (state_q == WRITE) && !fifo_full;
  assign fifo_wdata = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (start_PE) begin
          a_d     = a_row;
          b_d     = b_col;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        // size cast keeps the product's sign
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!fifo_full) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_dot_product_pe.sv
// Scoreboard bench for dot_product_pe: driver queues expected sums,
// a negedge monitor pops and compares on every fifo_push.
module tb_dot_product_pe;
  localparam int DW = 8;
  localparam int K  = 4;
  localparam int AW = 2*DW + $clog2(K);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_PE;
  logic [K*DW-1:0] a_row, b_col;
  logic          fifo_full;
  logic          PE_ready, busy, fifo_push;
  logic signed [AW-1:0] fifo_wdata;

  dot_product_pe #(.DATA_W(DW), .K(K)) dut (
    .clk(clk), .rst(rst), .start_PE(start_PE),
    .a_row(a_row), .b_col(b_col), .fifo_full(fifo_full),
    .PE_ready(PE_ready), .busy(busy),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint exp_q[$];
  int     push_cyc[$];
  int     npush = 0;
  int     passed = 0;
  int     total = 0;
  int     acc_cyc = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (fifo_push) begin
      npush++;
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
      else chk("push_data", longint'(fifo_wdata), exp_q.pop_front());
    end
  end

  function automatic longint model(int a[K], int b[K]);
    longint s = 0;
    for (int i = 0; i < K; i++) s += longint'(a[i]) * longint'(b[i]);
    return s;
  endfunction

  task automatic set_in(int a[K], int b[K]);
    for (int i = 0; i < K; i++) begin
      a_row[i*DW +: DW] = a[i][DW-1:0];
      b_col[i*DW +: DW] = b[i][DW-1:0];
    end
  endtask

  task automatic rnd_vec(output int v[K]);
    for (int i = 0; i < K; i++) v[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!PE_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!PE_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(int a[K], int b[K], bit hold);
    set_in(a, b);
    start_PE = 1'b1;
    wait_ready();
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) start_PE = 1'b0;
  endtask

  task automatic wait_pushes(int target, bit rnd_full);
    int n = 0;
    while (npush < target && n < 300) begin
      @(posedge clk);
      #1;
      if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
      n++;
    end
    fifo_full = 1'b0;
    if (npush < target) chk("push_timeout", npush, target);
  endtask

  initial begin
    int a[K], b[K];
    int a3[3][K], b3[3][K];
    longint e;
    int base;

    rst = 1'b1; start_PE = 1'b0; fifo_full = 1'b0;
    a_row = '0; b_col = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", PE_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_wdata", fifo_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic
    a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
    issue(a, b, 0);
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    wait_pushes(1, 0);
    chk("basic_latency", push_cyc[0] - acc_cyc, K);
    #1;
    chk("ready_after_push", PE_ready, 1);

    // signed extremes
    a = '{-128, -128, -128, -128}; b = '{-128, -128, -128, -128};
    chk("model_min_min", model(a, b), 65536);
    issue(a, b, 0);
    b = '{127, 127, 127, 127};
    issue(a, b, 0);
    a = '{3, -2, 0, -1}; b = '{-4, 5, 9, -6};
    issue(a, b, 0);
    wait_pushes(4, 0);

    // backpressure
    fifo_full = 1'b1;
    rnd_vec(a); rnd_vec(b);
    e = model(a, b);
    issue(a, b, 0);
    repeat (K) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_push", fifo_push, 0);
      chk("bp_wdata", longint'(fifo_wdata), e);
      chk("bp_ready", PE_ready, 0);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    wait_pushes(5, 0);
    chk("bp_latency", push_cyc[4] - acc_cyc, K + 3);

    // back-to-back with start held, inputs swapped right after accept
    for (int j = 0; j < 3; j++) begin
      rnd_vec(a); rnd_vec(b);
      a3[j] = a; b3[j] = b;
    end
    for (int j = 0; j < 3; j++) issue(a3[j], b3[j], 1);
    start_PE = 1'b0;
    wait_pushes(8, 0);
    chk("b2b_gap1", push_cyc[6] - push_cyc[5], K + 2);
    chk("b2b_gap2", push_cyc[7] - push_cyc[6], K + 2);
    repeat (10) @(posedge clk);
    chk("b2b_count", npush, 8);

    // random jobs with random backpressure
    for (int j = 0; j < 6; j++) begin
      rnd_vec(a); rnd_vec(b);
      issue(a, b, 0);
      wait_pushes(9 + j, 1);
    end

    // reset two cycles into MAC
    base = npush;
    rnd_vec(a); rnd_vec(b);
    set_in(a, b);
    start_PE = 1'b1;
    @(posedge clk); #1;
    start_PE = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", PE_ready, 1);
    chk("mid_rst_wdata", fifo_wdata, 0);
    repeat (10) @(posedge clk);
    chk("mid_rst_no_push", npush, base);
    #1;
    a = '{-7, 100, 55, -128}; b = '{9, -3, 127, 2};
    issue(a, b, 0);
    wait_pushes(base + 1, 0);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
